gmii_rx_parse: RTL and testbench
================================

# gmii_rx_parse

Receive-side GMII frame parser for the HDMI-over-Ethernet link. It sits directly downstream of the PHY on the receiving board and consumes the UDP frames produced by the transmit stage: video, audio and video+aux. It strips the Ethernet, IP and UDP headers, filters on destination MAC and UDP port, and splits the payload into a pixel write stream and an audio-aux write stream. A per-frame good or bad verdict is issued at the end of each frame, and the downstream line buffers commit or discard the frame on that verdict.

## Interface
Parameters:
- `my_mac`, default `48'h002345678902`: destination MAC that is accepted.
- `udp_port`, default `16'h3039`: UDP destination port that is accepted.
- `pix_bytes`, default `11'd1200`: pixel bytes following the 2-byte line header.
- `aux_bytes`, default `6'd32`: payload bytes per aux block.

Ports:
- `rx_clk` input 1: GMII receive clock, 125 MHz. Only clock.
- `sys_rst_n` input 1: asynchronous, active-low reset.
- `rx_dv` input 1: GMII data valid.
- `rx_er` input 1: GMII receive error.
- `rxd` input 8: GMII data.
- `vid_wr_en` output 1: pixel byte strobe.
- `vid_data` output 8: pixel byte.
- `vid_idx` output 11: byte index within the line, 0 to `pix_bytes`-1.
- `vid_line` output 16: line header {hdr0, hdr1}, latched per frame.
- `aux_wr_en` output 1: aux payload byte strobe.
- `aux_data` output 8: aux payload byte.
- `pkt_type` output 2: last packet id (0 video, 1 audio, 2 vidax).
- `frame_ok` output 1: one-cycle pulse when a frame passes all checks.
- `frame_err` output 1: one-cycle pulse when an accepted-header frame fails.

## Operation
States: IDLE, PRE, ETH, IPH, UDPH, PID, RESOL, PIX, AUXID, AUX, FCS, DRAIN.
- **IDLE:** on `rx_dv`=1 with `rxd`=0x55, go to PRE.
- **PRE:** 0x55 repeats are accepted. 0xD5 after at least 1 preamble byte goes to ETH. Any other byte goes to DRAIN.
- **ETH (14 bytes):** bytes 0–5 must equal `my_mac`. Bytes 12–13 must equal 0x0800. Mismatch goes to DRAIN with no error pulse (frame not for us).
- **IPH (20 bytes):** byte 0 must be 0x45 and byte 9 must be 0x11, else DRAIN with no pulse. The checksum is not verified.
- **UDPH (8 bytes):** bytes 2–3 must equal `udp_port`, else DRAIN with no pulse.
- **PID (1 byte):** latch `pkt_type`.
  - 0 or 2 goes to RESOL.
  - 1 goes to AUXID.
  - Other values go to DRAIN with `frame_err`.
- **RESOL (2 bytes):** capture `vid_line`, then go to PIX.
- **PIX:** emit `pix_bytes` bytes on the video stream with `vid_idx` 0..N-1. After the last byte, type 0 goes to FCS and type 2 goes to AUXID.
- **AUXID (2 bytes):** byte 0 is ignored. Byte 1[7:4] is the blocks remaining including this one; latch it as `left`. Then go to AUX.
- **AUX:** emit `aux_bytes` bytes on the aux stream. At the end of the block, `left` ≤ 1 goes to FCS; otherwise go to AUXID.
- **FCS (4 bytes):** compare against the CRC (see Configuration). Emit the verdict pulse, then go to DRAIN.
- **DRAIN:** wait for `rx_dv`=0, then go to IDLE.

Errors:
- `rx_dv` falling in any state from PID through FCS (before FCS completes) produces `frame_err`, then IDLE.
- `rx_er`=1 at any point after SFD sets a sticky bad flag, which forces `frame_err` instead of `frame_ok` at the verdict.
- Bytes after FCS while `rx_dv` is still high are ignored in DRAIN.
- A frame is never both ok and err.

## Timing
- All outputs are registered.
- Reset values are 0 for every output: strobes low, data 0, `vid_line` 0, `pkt_type` 0. The state machine resets to DRAIN, so a frame already in progress at reset release is skipped.
- Latency: a payload byte on `rxd` at edge n appears on `vid_data`/`aux_data` with its strobe at edge n+1. `vid_idx` is aligned with `vid_wr_en`.
- The verdict pulse occurs 1 cycle after the 4th FCS byte is sampled.
- `frame_err` for a dv-drop occurs 1 cycle after `rx_dv` is sampled low.
- `vid_wr_en` and `aux_wr_en` are never high in the same cycle.
- There is no backpressure: downstream must accept 1 byte per cycle.
- Byte counters are 11 bits. A counter reaching its terminal value is the only transition trigger, with no wrap beyond it.

## Configuration
- `GMII_RX_CRC_EN` defined:
  - A CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) is computed over all bytes from dst MAC through the last payload byte.
  - The residue after FCS must equal 0xC704DD7B for `frame_ok`.
  - A mismatch produces `frame_err`.
- Not defined:
  - FCS bytes are consumed without checking.
  - `frame_ok` is issued unless dv-drop or `rx_er` occurred.
  - No CRC logic is instantiated.

## Test plan
- **Video frame:** pkt_type 0, line header 0x02D0, 1200 pixel bytes 0x00..0xAF repeating, valid FCS. Expect 1200 `vid_wr_en` strobes with `vid_idx` 0..1199, `vid_line`=0x02D0, one `frame_ok`, zero `aux_wr_en`.
- **Vidax frame:** 1200 pixels plus 2 aux blocks (AUXID byte 1 = 0x20, then 0x10), 32 bytes each. Expect 1200 video strobes then 64 aux strobes, then `frame_ok`.
- **Audio frame with bad FCS** (`GMII_RX_CRC_EN` set): 1 aux block, last FCS byte inverted. Expect 32 aux strobes, then `frame_err`, no `frame_ok`.
- **Filtering:** dst MAC …:01, or UDP port 0x3038. Expect no strobes and no verdict pulses; the next valid frame is parsed normally.
- **Truncation:** `rx_dv` drops after pixel 500. Expect 500 video strobes, `frame_err` 1 cycle after the drop, then a clean parse of the next frame.
- **Reset mid-frame:** `sys_rst_n` pulsed low during PIX. Outputs go to 0 immediately; the remainder of that frame is ignored; the following frame yields `frame_ok`.

Source files
------------

// File: rtl/gmii_rx_parse.sv
// gmii_rx_parse: receive-side GMII frame parser for the HDMI-over-Ethernet link.
// Strips Ethernet/IPv4/UDP headers and filters on destination MAC and UDP port.
// Splits the payload into a pixel write stream and an audio/aux write stream.
// Issues a one-cycle good/bad verdict per accepted frame.
// Optional build macro: GMII_RX_CRC_EN turns on CRC-32 FCS checking.
// Without it, FCS bytes are skipped and no CRC logic exists.
module gmii_rx_parse #(
  parameter logic [47:0] my_mac    = 48'h002345678902,
  parameter logic [15:0] udp_port  = 16'h3039,
  parameter logic [10:0] pix_bytes = 11'd1200,
  parameter logic [5:0]  aux_bytes = 6'd32
) (
  input  logic        rx_clk,
  input  logic        sys_rst_n,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic        vid_wr_en,
  output logic [7:0]  vid_data,
  output logic [10:0] vid_idx,
  output logic [15:0] vid_line,
  output logic        aux_wr_en,
  output logic [7:0]  aux_data,
  output logic [1:0]  pkt_type,
  output logic        frame_ok,
  output logic        frame_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_ETH, S_IPH, S_UDPH, S_PID, S_RESOL,
    S_PIX, S_AUXID, S_AUX, S_FCS, S_DRAIN
  } state_t;

  localparam logic [10:0] PIX_LAST = pix_bytes - 11'd1;
  localparam logic [10:0] AUX_LAST = {5'd0, aux_bytes} - 11'd1;

  state_t      state_q;
  logic [10:0] cnt_q;
  logic [3:0]  left_q;
  logic [7:0]  hdr0_q;
  logic        bad_q;

  logic        vid_wr_en_q;
  logic [7:0]  vid_data_q;
  logic [10:0] vid_idx_q;
  logic [15:0] vid_line_q;
  logic        aux_wr_en_q;
  logic [7:0]  aux_data_q;
  logic [1:0]  pkt_type_q;
  logic        frame_ok_q;
  logic        frame_err_q;

  logic [10:0] cnt_inc_d;
  logic        bad_d;
  logic [7:0]  mac_byte_d;
  logic        eth_ok_d;
  logic        iph_ok_d;
  logic        udph_ok_d;
  logic        in_frame_d;
  logic        in_payload_d;
  logic        crc_ok_d;

  assign vid_wr_en = vid_wr_en_q;
  assign vid_data  = vid_data_q;
  assign vid_idx   = vid_idx_q;
  assign vid_line  = vid_line_q;
  assign aux_wr_en = aux_wr_en_q;
  assign aux_data  = aux_data_q;
  assign pkt_type  = pkt_type_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;

  // Shared helpers: counter increment, sticky error, state-range flags
  always_comb begin
    cnt_inc_d    = cnt_q + 11'd1;
    bad_d        = bad_q | rx_er;
    in_frame_d   = state_q inside {S_ETH, S_IPH, S_UDPH, S_PID, S_RESOL,
                                   S_PIX, S_AUXID, S_AUX, S_FCS};
    in_payload_d = state_q inside {S_PID, S_RESOL, S_PIX, S_AUXID, S_AUX, S_FCS};
  end

  // Destination MAC byte expected at the current ETH position (wire order, MSB first)
  always_comb begin
    case (cnt_q[2:0])
      3'd0:    mac_byte_d = my_mac[47:40];
      3'd1:    mac_byte_d = my_mac[39:32];
      3'd2:    mac_byte_d = my_mac[31:24];
      3'd3:    mac_byte_d = my_mac[23:16];
      3'd4:    mac_byte_d = my_mac[15:8];
      3'd5:    mac_byte_d = my_mac[7:0];
      default: mac_byte_d = 8'h00;
    endcase
  end

  // Per-byte header field checks; positions not listed are don't-care
  always_comb begin
    eth_ok_d = 1'b1;
    if (cnt_q < 11'd6)        eth_ok_d = (rxd == mac_byte_d);
    else if (cnt_q == 11'd12) eth_ok_d = (rxd == 8'h08);
    else if (cnt_q == 11'd13) eth_ok_d = (rxd == 8'h00);

    iph_ok_d = 1'b1;
    if (cnt_q == 11'd0)       iph_ok_d = (rxd == 8'h45);
    else if (cnt_q == 11'd9)  iph_ok_d = (rxd == 8'h11);

    udph_ok_d = 1'b1;
    if (cnt_q == 11'd2)       udph_ok_d = (rxd == udp_port[15:8]);
    else if (cnt_q == 11'd3)  udph_ok_d = (rxd == udp_port[7:0]);
  end

`ifdef GMII_RX_CRC_EN
  // Good-frame residue in MSB-first form; the reflected register is bit-reversed before comparing
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] crc_rev_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Next CRC value with the byte currently on rxd folded in
  always_comb crc_d = crc_byte(crc_q, rxd);

  for (genvar gi = 0; gi < 32; gi++) begin : g_crc_rev
    assign crc_rev_d[gi] = crc_d[31-gi];
  end

  assign crc_ok_d = (crc_rev_d == CRC_RESIDUE);

  // CRC register: reseeded during preamble and advanced on every byte from dst MAC through FCS
  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)               crc_q <= 32'hFFFFFFFF;
    else if (state_q == S_PRE)    crc_q <= 32'hFFFFFFFF;
    else if (rx_dv && in_frame_d) crc_q <= crc_d;
  end
`else
  assign crc_ok_d = 1'b1;
`endif

  // Parser FSM with registered stream outputs and verdict pulses
  always_ff @(posedge rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_DRAIN;
      cnt_q       <= 11'd0;
      left_q      <= 4'd0;
      hdr0_q      <= 8'd0;
      bad_q       <= 1'b0;
      vid_wr_en_q <= 1'b0;
      vid_data_q  <= 8'd0;
      vid_idx_q   <= 11'd0;
      vid_line_q  <= 16'd0;
      aux_wr_en_q <= 1'b0;
      aux_data_q  <= 8'd0;
      pkt_type_q  <= 2'd0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      vid_wr_en_q <= 1'b0;
      aux_wr_en_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (rx_dv && in_frame_d) bad_q <= bad_d;

      if (!rx_dv && in_payload_d) begin
        // Truncated frame once the header was accepted
        frame_err_q <= 1'b1;
        state_q     <= S_IDLE;
      end else if (!rx_dv && state_q inside {S_PRE, S_ETH, S_IPH, S_UDPH}) begin
        // Dropped before acceptance: not our frame, stay silent
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (rx_dv && rxd == 8'h55) state_q <= S_PRE;
          S_PRE: begin
            if (rxd == 8'hD5) begin
              state_q <= S_ETH;
              cnt_q   <= 11'd0;
              bad_q   <= 1'b0;
            end else if (rxd != 8'h55) begin
              state_q <= S_DRAIN;
            end
          end
          S_ETH: begin
            if (!eth_ok_d)               state_q <= S_DRAIN;
            else if (cnt_q == 11'd13) begin
              state_q <= S_IPH;
              cnt_q   <= 11'd0;
            end else                     cnt_q <= cnt_inc_d;
          end
          S_IPH: begin
            if (!iph_ok_d)               state_q <= S_DRAIN;
            else if (cnt_q == 11'd19) begin
              state_q <= S_UDPH;
              cnt_q   <= 11'd0;
            end else                     cnt_q <= cnt_inc_d;
          end
          S_UDPH: begin
            if (!udph_ok_d)              state_q <= S_DRAIN;
            else if (cnt_q == 11'd7) begin
              state_q <= S_PID;
              cnt_q   <= 11'd0;
            end else                     cnt_q <= cnt_inc_d;
          end
          S_PID: begin
            cnt_q <= 11'd0;
            if (rxd == 8'd0 || rxd == 8'd2) begin
              pkt_type_q <= rxd[1:0];
              state_q    <= S_RESOL;
            end else if (rxd == 8'd1) begin
              pkt_type_q <= 2'd1;
              state_q    <= S_AUXID;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_DRAIN;
            end
          end
          S_RESOL: begin
            if (cnt_q == 11'd0) begin
              hdr0_q <= rxd;
              cnt_q  <= 11'd1;
            end else begin
              vid_line_q <= {hdr0_q, rxd};
              cnt_q      <= 11'd0;
              state_q    <= S_PIX;
            end
          end
          S_PIX: begin
            vid_wr_en_q <= 1'b1;
            vid_data_q  <= rxd;
            vid_idx_q   <= cnt_q;
            if (cnt_q == PIX_LAST) begin
              cnt_q   <= 11'd0;
              state_q <= (pkt_type_q == 2'd2) ? S_AUXID : S_FCS;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          S_AUXID: begin
            if (cnt_q == 11'd0) begin
              cnt_q <= 11'd1;
            end else begin
              left_q  <= rxd[7:4];
              cnt_q   <= 11'd0;
              state_q <= S_AUX;
            end
          end
          S_AUX: begin
            aux_wr_en_q <= 1'b1;
            aux_data_q  <= rxd;
            if (cnt_q == AUX_LAST) begin
              cnt_q   <= 11'd0;
              state_q <= (left_q <= 4'd1) ? S_FCS : S_AUXID;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          S_FCS: begin
            if (cnt_q == 11'd3) begin
              if (bad_d || !crc_ok_d) frame_err_q <= 1'b1;
              else                    frame_ok_q  <= 1'b1;
              cnt_q   <= 11'd0;
              state_q <= S_DRAIN;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          S_DRAIN: if (!rx_dv) state_q <= S_IDLE;
          default: state_q <= S_DRAIN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_parse.sv
// tb_gmii_rx_parse: scoreboard bench for gmii_rx_parse.
// Frames are assembled from fields by a frame-level model that also annotates each byte with its expected output.
// The driver pushes expectations as bytes go out; a negedge monitor pops and compares.
module tb_gmii_rx_parse;

  localparam logic [47:0] MY_MAC   = 48'h002345678902;
  localparam logic [15:0] UDP_PORT = 16'h3039;
`ifdef GMII_RX_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  rxd = 8'd0;
  logic        vid_wr_en;
  logic [7:0]  vid_data;
  logic [10:0] vid_idx;
  logic [15:0] vid_line;
  logic        aux_wr_en;
  logic [7:0]  aux_data;
  logic [1:0]  pkt_type;
  logic        frame_ok;
  logic        frame_err;

  gmii_rx_parse dut (
    .rx_clk(clk), .sys_rst_n(sys_rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .vid_wr_en(vid_wr_en), .vid_data(vid_data), .vid_idx(vid_idx), .vid_line(vid_line),
    .aux_wr_en(aux_wr_en), .aux_data(aux_data), .pkt_type(pkt_type),
    .frame_ok(frame_ok), .frame_err(frame_err)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [10:0] idx; logic [7:0] data; logic [15:0] line; } vid_exp_t;
  typedef struct { int cyc; logic [7:0] data; } aux_exp_t;
  typedef struct { int cyc; logic ok; logic [1:0] ptype; } ver_exp_t;

  vid_exp_t vid_q[$];
  aux_exp_t aux_q[$];
  ver_exp_t ver_q[$];

  int n_chk = 0;
  int n_fail = 0;

  // Current frame, byte by byte: kind 0 = none, 1 = pixel, 2 = aux, 3 = verdict after this byte
  logic [7:0]  fb[$];
  int          fk[$];
  int          fi[$];
  int          fcrc0, fpid, fpix0;
  logic [1:0]  fptype;
  logic [15:0] fline;
  bit          faccept, fcs_good;
  int          frame_no = 0;

  function automatic void add(input logic [7:0] b, input int k, input int idx);
    fb.push_back(b);
    fk.push_back(k);
    fi.push_back(idx);
  endfunction

  // Standard Ethernet FCS of fb[from..end]: reflected CRC-32, complemented
  function automatic logic [31:0] fcs_of(input int from);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = from; i < fb.size(); i++) begin
      c = c ^ {24'd0, fb[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input logic [1:0] ptype, input logic [7:0] mac_lsb, input logic [15:0] port,
                       input int nblk, input logic [15:0] line, input bit patterned, input bit bad_fcs);
    int pre;
    logic [31:0] crc;
    logic [47:0] mac;
    fb.delete(); fk.delete(); fi.delete();
    pre = $urandom_range(1, 7);
    repeat (pre) add(8'h55, 0, 0);
    add(8'hD5, 0, 0);
    fcrc0 = fb.size();
    mac = {MY_MAC[47:8], mac_lsb};
    for (int j = 0; j < 6; j++) add(mac[8*(5-j) +: 8], 0, 0);
    for (int j = 0; j < 6; j++) add(8'($urandom), 0, 0);
    add(8'h08, 0, 0);
    add(8'h00, 0, 0);
    for (int j = 0; j < 20; j++) add((j == 0) ? 8'h45 : ((j == 9) ? 8'h11 : 8'($urandom)), 0, 0);
    add(8'($urandom), 0, 0);
    add(8'($urandom), 0, 0);
    add(port[15:8], 0, 0);
    add(port[7:0], 0, 0);
    for (int j = 0; j < 4; j++) add(8'($urandom), 0, 0);
    fpid = fb.size();
    add({6'd0, ptype}, 0, 0);
    fptype = ptype;
    fline = line;
    fpix0 = -1;
    if (ptype != 2'd1) begin
      add(line[15:8], 0, 0);
      add(line[7:0], 0, 0);
      fpix0 = fb.size();
      for (int j = 0; j < 1200; j++) add(patterned ? 8'(j % 176) : 8'($urandom), 1, j);
    end
    if (ptype != 2'd0) begin
      for (int k = 0; k < nblk; k++) begin
        add(8'($urandom), 0, 0);
        add({4'(nblk - k), 4'($urandom)}, 0, 0);
        for (int j = 0; j < 32; j++) add(8'($urandom), 2, j);
      end
    end
    crc = fcs_of(fcrc0);
    add(crc[7:0], 0, 0);
    add(crc[15:8], 0, 0);
    add(crc[23:16], 0, 0);
    add(bad_fcs ? ~crc[31:24] : crc[31:24], 3, 0);
    faccept = (mac == MY_MAC) && (port == UDP_PORT);
    fcs_good = !(bad_fcs && CRC_EN);
  endtask

  task automatic check_zero(input string name);
    logic [59:0] outs;
    outs = {vid_wr_en, vid_data, vid_idx, vid_line, aux_wr_en, aux_data, pkt_type, frame_ok, frame_err};
    n_chk++;
    if (outs != 60'd0) begin
      n_fail++;
      $display("FAIL %s: outputs=%h, required all zero", name, outs);
    end
  endtask

  // Drive the current frame; drop_at/er_at/rst_at are byte positions, -1 for none
  task automatic send(input int drop_at, input int er_at, input int rst_at);
    bit live, ok, dropped;
    vid_exp_t ve;
    aux_exp_t ae;
    ver_exp_t re;
    live = faccept;
    ok = fcs_good && !(er_at >= fcrc0);
    dropped = 1'b0;
    frame_no++;
    $display("frame %0d: type=%0d bytes=%0d accept=%0d drop_at=%0d er_at=%0d rst_at=%0d expect_ok=%0d",
             frame_no, fptype, fb.size(), faccept, drop_at, er_at, rst_at, ok);
    for (int i = 0; i < fb.size(); i++) begin
      @(posedge clk); #1;
      if (i == drop_at) begin
        rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'd0;
        if (live && i >= fpid) begin
          re.cyc = cyc + 1; re.ok = 1'b0; re.ptype = fptype;
          ver_q.push_back(re);
        end
        dropped = 1'b1;
        break;
      end
      if (i == rst_at) begin
        #1 sys_rst_n = 1'b0;
        #1 check_zero("reset_mid_frame");
        vid_q.delete(); aux_q.delete(); ver_q.delete();
        live = 1'b0;
        #2 sys_rst_n = 1'b1;
      end
      rx_dv = 1'b1;
      rx_er = (i == er_at);
      rxd = fb[i];
      if (live) begin
        case (fk[i])
          1: begin
            ve.cyc = cyc + 1; ve.idx = 11'(fi[i]); ve.data = fb[i]; ve.line = fline;
            vid_q.push_back(ve);
          end
          2: begin
            ae.cyc = cyc + 1; ae.data = fb[i];
            aux_q.push_back(ae);
          end
          3: begin
            re.cyc = cyc + 1; re.ok = ok; re.ptype = fptype;
            ver_q.push_back(re);
          end
          default: ;
        endcase
      end
    end
    if (!dropped) begin
      @(posedge clk); #1;
      rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'd0;
    end
    repeat (12) @(posedge clk);
  endtask

  // Monitor: pop and compare whenever the DUT presents a strobe or verdict
  always @(negedge clk) begin
    vid_exp_t ve;
    aux_exp_t ae;
    ver_exp_t re;
    if (vid_wr_en || aux_wr_en) begin
      n_chk++;
      if (vid_wr_en && aux_wr_en) begin
        n_fail++;
        $display("FAIL stream_excl: vid_wr_en=1 aux_wr_en=1, required at most one");
      end
    end
    if (vid_wr_en) begin
      n_chk++;
      if (vid_q.size() == 0) begin
        n_fail++;
        $display("FAIL vid_unexpected: data=%h idx=%0d cyc=%0d, required no strobe", vid_data, vid_idx, cyc);
      end else begin
        ve = vid_q.pop_front();
        if (vid_data != ve.data || vid_idx != ve.idx || vid_line != ve.line || cyc != ve.cyc) begin
          n_fail++;
          $display("FAIL vid: data=%h idx=%0d line=%h cyc=%0d, required data=%h idx=%0d line=%h cyc=%0d",
                   vid_data, vid_idx, vid_line, cyc, ve.data, ve.idx, ve.line, ve.cyc);
        end
      end
    end
    if (aux_wr_en) begin
      n_chk++;
      if (aux_q.size() == 0) begin
        n_fail++;
        $display("FAIL aux_unexpected: data=%h cyc=%0d, required no strobe", aux_data, cyc);
      end else begin
        ae = aux_q.pop_front();
        if (aux_data != ae.data || cyc != ae.cyc) begin
          n_fail++;
          $display("FAIL aux: data=%h cyc=%0d, required data=%h cyc=%0d", aux_data, cyc, ae.data, ae.cyc);
        end
      end
    end
    if (frame_ok || frame_err) begin
      n_chk++;
      if (ver_q.size() == 0) begin
        n_fail++;
        $display("FAIL verdict_unexpected: ok=%0d err=%0d cyc=%0d, required no verdict", frame_ok, frame_err, cyc);
      end else begin
        re = ver_q.pop_front();
        if (frame_ok != re.ok || frame_err != !re.ok || pkt_type != re.ptype || cyc != re.cyc) begin
          n_fail++;
          $display("FAIL verdict: ok=%0d err=%0d pkt_type=%0d cyc=%0d, required ok=%0d err=%0d pkt_type=%0d cyc=%0d",
                   frame_ok, frame_err, pkt_type, cyc, re.ok, !re.ok, re.ptype, re.cyc);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge clk);
    #1 check_zero("reset_state");
    sys_rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Video frame with patterned pixels
    build(2'd0, 8'h02, UDP_PORT, 0, 16'h02D0, 1'b1, 1'b0);
    send(-1, -1, -1);
    // Video + aux, two blocks
    build(2'd2, 8'h02, UDP_PORT, 2, 16'h0123, 1'b0, 1'b0);
    send(-1, -1, -1);
    // Audio frame with corrupted FCS
    build(2'd1, 8'h02, UDP_PORT, 1, 16'h0000, 1'b0, 1'b1);
    send(-1, -1, -1);
    // Filtered: wrong MAC, then wrong port, then a normal frame
    build(2'd0, 8'h01, UDP_PORT, 0, 16'h0042, 1'b0, 1'b0);
    send(-1, -1, -1);
    build(2'd2, 8'h02, 16'h3038, 1, 16'h0043, 1'b0, 1'b0);
    send(-1, -1, -1);
    build(2'd1, 8'h02, UDP_PORT, 3, 16'h0000, 1'b0, 1'b0);
    send(-1, -1, -1);
    // Truncation after pixel 500, then a clean frame
    build(2'd0, 8'h02, UDP_PORT, 0, 16'h0100, 1'b0, 1'b0);
    send(fpix0 + 500, -1, -1);
    build(2'd0, 8'h02, UDP_PORT, 0, 16'h0101, 1'b0, 1'b0);
    send(-1, -1, -1);
    // Reset pulse during pixels, then a clean frame
    build(2'd2, 8'h02, UDP_PORT, 1, 16'h0200, 1'b0, 1'b0);
    send(-1, -1, fpix0 + 300);
    build(2'd0, 8'h02, UDP_PORT, 0, 16'h0201, 1'b0, 1'b0);
    send(-1, -1, -1);
    // rx_er inside the payload forces an error verdict
    build(2'd2, 8'h02, UDP_PORT, 2, 16'h0300, 1'b0, 1'b0);
    send(-1, fpix0 + 77, -1);
    // Random frames
    for (int r = 0; r < 4; r++) begin
      build(2'($urandom_range(0, 2)), 8'h02, UDP_PORT, $urandom_range(1, 3),
            16'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      send(-1, -1, -1);
    end

    repeat (20) @(posedge clk);
    n_chk++;
    if (vid_q.size() != 0) begin
      n_fail++;
      $display("FAIL vid_pending: %0d entries left, required 0", vid_q.size());
    end
    n_chk++;
    if (aux_q.size() != 0) begin
      n_fail++;
      $display("FAIL aux_pending: %0d entries left, required 0", aux_q.size());
    end
    n_chk++;
    if (ver_q.size() != 0) begin
      n_fail++;
      $display("FAIL verdict_pending: %0d entries left, required 0", ver_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
